// File: rtl/local_bus_master.sv
// SURF local-bus initiator: turns one request into len back-to-back single-word
// transfers (ADDR, WAIT, DATA, TURN) with a ready timeout and sticky error flag.
module local_bus_master #(
  parameter int TIMEOUT  = 64,
  parameter int LEN_BITS = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [1:0]          space_i,
  input  logic [5:0]          addr_i,
  input  logic [LEN_BITS-1:0] len_i,
  input  logic [31:0]         wdata_i,
  output logic                busy_o,
  output logic [31:0]         rdata_o,
  output logic                rdata_valid_o,
  output logic                done_o,
  output logic                err_o,
  output logic                nADS,
  output logic                WnR,
  output logic                nCS2,
  output logic                nCS3,
  output logic                nRD,
  output logic [5:0]          LA,
  inout  wire  [31:0]         LD,
  input  logic                nREADY
);

  localparam int WCNT_W = $clog2(TIMEOUT + 2);
  // The first WAIT cycle never samples nREADY, so it is not counted toward the timeout.
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MIN  = WCNT_W'(2);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_DATA, S_TURN} state_t;

  state_t              state;
  logic                we_q;
  logic [1:0]          space_q;
  logic [31:0]         wdata_q;
  logic [LEN_BITS-1:0] rem;
  logic [WCNT_W-1:0]   wcnt;
  logic                ld_oe;

  // Returns {nCS2, nCS3}; space 3 aliases register space.
  function automatic logic [1:0] cs_for(input logic [1:0] sp);
    case (sp)
      2'd1:    cs_for = 2'b01;
      2'd2:    cs_for = 2'b10;
      default: cs_for = 2'b11;
    endcase
  endfunction

  assign LD = ld_oe ? wdata_q : 'z;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      we_q          <= 1'b0;
      space_q       <= 2'd0;
      wdata_q       <= '0;
      rem           <= '0;
      wcnt          <= '0;
      ld_oe         <= 1'b0;
      busy_o        <= 1'b0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      nADS          <= 1'b1;
      WnR           <= 1'b0;
      nCS2          <= 1'b1;
      nCS3          <= 1'b1;
      nRD           <= 1'b1;
      LA            <= '0;
    end else begin
      done_o        <= 1'b0;
      rdata_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            we_q         <= we_i;
            space_q      <= space_i;
            wdata_q      <= wdata_i;
            rem          <= (len_i == '0) ? LEN_BITS'(1) : len_i;
            busy_o       <= 1'b1;
            err_o        <= 1'b0;
            nADS         <= 1'b0;
            WnR          <= we_i;
            {nCS2, nCS3} <= cs_for(space_i);
            LA           <= addr_i;
            ld_oe        <= we_i;
            state        <= S_ADDR;
          end
        end
        S_ADDR: begin
          nADS  <= 1'b1;
          nRD   <= we_q;
          wcnt  <= WCNT_W'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt >= WCNT_MIN && !nREADY) begin
            state <= S_DATA;
          end else if (wcnt == WCNT_LAST) begin
            err_o        <= 1'b1;
            rem          <= '0;
            nRD          <= 1'b1;
            WnR          <= 1'b0;
            {nCS2, nCS3} <= 2'b11;
            ld_oe        <= 1'b0;
            state        <= S_TURN;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        S_DATA: begin
          if (!we_q) begin
            rdata_o       <= LD;
            rdata_valid_o <= 1'b1;
          end
          nRD          <= 1'b1;
          WnR          <= 1'b0;
          {nCS2, nCS3} <= 2'b11;
          ld_oe        <= 1'b0;
          state        <= S_TURN;
        end
        S_TURN: begin
          if (rem > LEN_BITS'(1)) begin
            rem          <= rem - LEN_BITS'(1);
            nADS         <= 1'b0;
            WnR          <= we_q;
            {nCS2, nCS3} <= cs_for(space_q);
            ld_oe        <= we_q;
            state        <= S_ADDR;
          end else begin
            rem    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_bus_master.sv
// Directed bench for local_bus_master with a minimum-latency SURF target model.
module tb_local_bus_master;
  localparam int TIMEOUT  = 64;
  localparam int LEN_BITS = 11;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                req_i = 1'b0;
  logic                we_i = 1'b0;
  logic [1:0]          space_i = 2'd0;
  logic [5:0]          addr_i = 6'd0;
  logic [LEN_BITS-1:0] len_i = '0;
  logic [31:0]         wdata_i = '0;
  logic                busy_o, rdata_valid_o, done_o, err_o;
  logic                nADS, WnR, nCS2, nCS3, nRD, nREADY;
  logic [31:0]         rdata_o;
  logic [5:0]          LA;
  wire  [31:0]         LD;

  int n_checks = 0;
  int n_fail   = 0;

  local_bus_master #(.TIMEOUT(TIMEOUT), .LEN_BITS(LEN_BITS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .space_i(space_i),
    .addr_i(addr_i), .len_i(len_i), .wdata_i(wdata_i), .busy_o(busy_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o), .err_o(err_o),
    .nADS(nADS), .WnR(WnR), .nCS2(nCS2), .nCS3(nCS3), .nRD(nRD), .LA(LA), .LD(LD),
    .nREADY(nREADY)
  );

  always #5 clk_i = ~clk_i;

  // Target model: ready in the second WAIT cycle, read data held through DATA.
  logic        tgt_oe;
  logic [31:0] tgt_ld;
  logic        tgt_hang = 1'b0;
  int          phase;
  logic        t_we;
  logic [1:0]  t_sp;
  logic [5:0]  t_addr;
  logic [31:0] mask_reg = 32'h0;
  logic [31:0] lab_cnt  = 32'h0;

  assign LD = tgt_oe ? tgt_ld : 'z;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase  <= 0;
      nREADY <= 1'b1;
      tgt_oe <= 1'b0;
      tgt_ld <= '0;
    end else if (!nADS) begin
      phase  <= 1;
      t_we   <= WnR;
      t_sp   <= !nCS3 ? 2'd2 : (!nCS2 ? 2'd1 : 2'd0);
      t_addr <= LA;
    end else if (phase == 1) begin
      if (tgt_hang) begin
        phase <= 0;
      end else begin
        nREADY <= 1'b0;
        phase  <= 2;
        if (!t_we) begin
          tgt_oe <= 1'b1;
          tgt_ld <= (t_sp == 2'd2) ? lab_cnt :
                    (t_addr == 6'd7) ? mask_reg :
                    (t_addr == 6'd0) ? 32'h5355_5246 : (32'hDEAD_0000 | {26'd0, t_addr});
        end
      end
    end else if (phase == 2) begin
      nREADY <= 1'b1;
      phase  <= 3;
    end else if (phase == 3) begin
      tgt_oe <= 1'b0;
      phase  <= 0;
      if (t_we && t_sp == 2'd0 && t_addr == 6'd7) mask_reg <= LD;
      if (!t_we && t_sp == 2'd2) lab_cnt <= lab_cnt + 32'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-request observations; cycle 0 is the ADDR cycle of the first word.
  int          cyc, done_cyc, nads_cnt, rv_cnt, ld_hold, cs_ok, la_ok, wnr_addr;
  logic [31:0] rd_q[$];
  logic        err_at_done, err_at_start, busy_at_start, busy_at_done;

  task automatic do_req(input logic we, input logic [1:0] sp, input logic [5:0] ad,
                        input logic [LEN_BITS-1:0] ln, input logic [31:0] wd,
                        input int poke_cyc, input int budget);
    logic [1:0] exp_cs;
    exp_cs = (sp == 2'd1) ? 2'b01 : (sp == 2'd2) ? 2'b10 : 2'b11;
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; space_i = sp; addr_i = ad; len_i = ln; wdata_i = wd;
    @(negedge clk_i);
    req_i = 1'b0;
    cyc = 0; done_cyc = -1; nads_cnt = 0; rv_cnt = 0; ld_hold = 0;
    cs_ok = 0; la_ok = 0; wnr_addr = 0; rd_q.delete();
    err_at_done = 1'b0; busy_at_done = 1'b1;
    err_at_start = err_o; busy_at_start = busy_o;
    while (done_cyc < 0 && cyc < budget) begin
      if (!nADS) begin
        nads_cnt++;
        if ({nCS2, nCS3} == exp_cs) cs_ok++;
        if (LA == ad) la_ok++;
        if (WnR) wnr_addr++;
      end
      if (LD === wd) ld_hold++;
      if (rdata_valid_o) begin
        rv_cnt++;
        rd_q.push_back(rdata_o);
      end
      if (done_o) begin
        done_cyc     = cyc;
        err_at_done  = err_o;
        busy_at_done = busy_o;
      end
      req_i = (cyc == poke_cyc);
      if (cyc == poke_cyc) len_i = 11'd7;
      @(negedge clk_i);
      cyc++;
    end
    req_i = 1'b0;
    check("done_seen", (done_cyc >= 0), 1);
    repeat (3) begin
      if (!nADS) nads_cnt++;
      @(negedge clk_i);
    end
  endtask

  logic seen_done;

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_ctl", {23'd0, nADS, nCS2, nCS3, nRD, WnR, busy_o, done_o, err_o, rdata_valid_o},
          32'b1_1110_0000);
    check("rst_la", LA, 0);
    check("rst_rdata", rdata_o, 0);
    rst_i = 1'b0;

    // Register read of the ID word
    do_req(1'b0, 2'd0, 6'd0, 11'd1, 32'h0, -1, 50);
    check("rd_done_cyc", done_cyc, 5);
    check("rd_nads", nads_cnt, 1);
    check("rd_cs", cs_ok, 1);
    check("rd_valid_cnt", rv_cnt, 1);
    check("rd_data", (rd_q.size() > 0) ? rd_q[0] : 32'hx, 32'h5355_5246);
    check("rd_err", err_at_done, 0);
    check("rd_busy_start", busy_at_start, 1);
    check("rd_busy_done", busy_at_done, 0);

    // Register write then readback of the mask register
    do_req(1'b1, 2'd0, 6'd7, 11'd1, 32'hA5A5_0F0F, -1, 50);
    check("wr_done_cyc", done_cyc, 5);
    check("wr_wnr", wnr_addr, 1);
    check("wr_ld_hold", ld_hold, 4);
    check("wr_valid_cnt", rv_cnt, 0);
    do_req(1'b0, 2'd0, 6'd7, 11'd1, 32'h0, -1, 50);
    check("wr_readback", (rd_q.size() > 0) ? rd_q[0] : 32'hx, 32'hA5A5_0F0F);

    // LAB burst read of 4 words
    do_req(1'b0, 2'd2, 6'd5, 11'd4, 32'h0, -1, 100);
    check("lab_done_cyc", done_cyc, 20);
    check("lab_nads", nads_cnt, 4);
    check("lab_cs", cs_ok, 4);
    check("lab_la", la_ok, 4);
    check("lab_valid_cnt", rv_cnt, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("lab_data%0d", i), (rd_q.size() > i) ? rd_q[i] : 32'hx, i);

    // HK write with len 0 behaves as a single word
    do_req(1'b1, 2'd1, 6'd3, 11'd0, 32'h1234_5678, -1, 50);
    check("hk_nads", nads_cnt, 1);
    check("hk_cs", cs_ok, 1);
    check("hk_done_cyc", done_cyc, 5);
    check("hk_ld_hold", ld_hold, 4);

    // Timeout with 3 words requested
    tgt_hang = 1'b1;
    do_req(1'b0, 2'd0, 6'd1, 11'd3, 32'h0, -1, 200);
    tgt_hang = 1'b0;
    check("to_err", err_at_done, 1);
    check("to_nads", nads_cnt, 1);
    check("to_done_cyc", done_cyc, TIMEOUT + 3);
    check("to_valid_cnt", rv_cnt, 0);
    check("to_err_sticky", err_o, 1);

    // Next request clears the error
    do_req(1'b0, 2'd0, 6'd0, 11'd1, 32'h0, -1, 50);
    check("clr_err_start", err_at_start, 0);
    check("clr_err_done", err_at_done, 0);
    check("clr_data", (rd_q.size() > 0) ? rd_q[0] : 32'hx, 32'h5355_5246);

    // Request pulsed while busy is ignored
    do_req(1'b0, 2'd0, 6'd0, 11'd2, 32'h0, 2, 60);
    check("busy_nads", nads_cnt, 2);
    check("busy_done_cyc", done_cyc, 10);
    check("busy_valid_cnt", rv_cnt, 2);

    // Reset during WAIT of word 2 in an 8-word LAB burst
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; space_i = 2'd2; addr_i = 6'd1; len_i = 11'd8;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check("mid_nrd_before", nRD, 0);
    check("mid_cs_before", {nCS2, nCS3}, 2'b10);
    #2 rst_i = 1'b1;
    #1;
    check("mid_ctl_after", {nADS, nCS2, nCS3, nRD, WnR, busy_o}, 6'b111100);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen_done = 1'b0;
    repeat (10) begin
      if (done_o || !nADS) seen_done = 1'b1;
      @(negedge clk_i);
    end
    check("mid_quiet", seen_done, 0);
    do_req(1'b0, 2'd0, 6'd0, 11'd1, 32'h0, -1, 50);
    check("mid_after_done_cyc", done_cyc, 5);
    check("mid_after_data", (rd_q.size() > 0) ? rd_q[0] : 32'hx, 32'h5355_5246);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
